// File: rtl/adc_emulator.sv
// ============================================================================
// Module      : adc_emulator
// Description : Responder-side model of an 8-bit, 8-input parallel ADC that
//               returns deterministic per-channel ramp data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_emulator #(
  parameter int CONV_CYCLES = 8,
  parameter int NUM_CH      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] chnl,
  input  logic       n_convst,
  input  logic       n_cs,
  input  logic       n_rd,
  output logic       n_eoc,
  output logic [7:0] adc_out,
  output logic       adc_oe,
  output logic       overrun,
  output logic [15:0] conv_count
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] CONVERTING = 2'd1;
  localparam logic [1:0] DONE       = 2'd2;

  localparam logic [7:0] CNT_LOAD = 8'(CONV_CYCLES - 1);
  localparam logic [3:0] LIVE_CH  = 4'(NUM_CH);

  logic [1:0] state;
  logic [1:0] state_next;
  logic       n_convst_q;
  logic       n_rd_q;
  logic [2:0] ch_lat;
  logic [7:0] cnt;
  logic [7:0] ramp [8];
  logic [7:0] result;
  logic       unread;
  logic       start;
  logic       read_done;
  logic       conv_done;
  logic       live;

  assign start     = n_convst_q & ~n_convst;
  assign read_done = ~n_rd_q & n_rd & ~n_cs;
  // A start in the final counting cycle aborts rather than completes.
  assign conv_done = (state == CONVERTING) && (cnt == 8'd0) && !start;
  assign live      = ({1'b0, ch_lat} < LIVE_CH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = CONVERTING;
      end
      CONVERTING: begin
        if (start)          state_next = CONVERTING;
        else if (conv_done) state_next = DONE;
      end
      DONE: begin
        if (start)          state_next = CONVERTING;
        else if (read_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    n_eoc = (state != DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_convst_q <= 1'b1;
      n_rd_q     <= 1'b1;
      ch_lat     <= 3'd0;
      cnt        <= 8'd0;
      result     <= 8'h00;
      unread     <= 1'b0;
      overrun    <= 1'b0;
      conv_count <= 16'd0;
      adc_oe     <= 1'b0;
      adc_out    <= 8'h00;
      for (int k = 0; k < 8; k++) begin
        ramp[k] <= 8'(k * 64);
      end
    end else begin
      n_convst_q <= n_convst;
      n_rd_q     <= n_rd;
      adc_oe     <= ~n_cs & ~n_rd;
      if (~n_cs & ~n_rd) begin
        adc_out <= result;
      end

      if (start) begin
        ch_lat <= chnl;
        cnt    <= CNT_LOAD;
      end else if (state == CONVERTING) begin
        if (conv_done) begin
          if (live) begin
            result       <= ramp[ch_lat];
            ramp[ch_lat] <= ramp[ch_lat] + {5'd0, ch_lat} + 8'd1;
          end else begin
            result <= 8'h00;
          end
          conv_count <= conv_count + 16'd1;
          unread     <= 1'b1;
          if (unread) begin
            overrun <= 1'b1;
          end
        end else begin
          cnt <= cnt - 8'd1;
        end
      end

      if (read_done && (state == DONE)) begin
        unread <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adc_emulator.sv
// ============================================================================
// Module      : tb_adc_emulator
// Description : Scoreboard bench for adc_emulator with a ramp reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_emulator;

  localparam int CONV = 8;
  localparam int NCH  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  chnl = 3'd0;
  logic        n_convst = 1'b1;
  logic        n_cs = 1'b1;
  logic        n_rd = 1'b1;
  logic        n_eoc;
  logic [7:0]  adc_out;
  logic        adc_oe;
  logic        overrun;
  logic [15:0] conv_count;

  adc_emulator #(.CONV_CYCLES(CONV), .NUM_CH(NCH)) dut (
    .clk(clk), .reset(reset), .chnl(chnl), .n_convst(n_convst),
    .n_cs(n_cs), .n_rd(n_rd), .n_eoc(n_eoc), .adc_out(adc_out),
    .adc_oe(adc_oe), .overrun(overrun), .conv_count(conv_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int exp_q[$];

  // Reference model state: ramp values as plain integers.
  int m_ramp [8];
  int m_count;
  int m_result;
  bit m_over;
  bit m_unread;
  bit m_done;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void m_reset();
    for (int k = 0; k < 8; k++) m_ramp[k] = (k * 64) % 256;
    m_count = 0; m_result = 0; m_over = 0; m_unread = 0; m_done = 0;
  endfunction

  function automatic void m_complete(input int ch);
    if (ch < NCH) begin
      m_result = m_ramp[ch];
      m_ramp[ch] = (m_ramp[ch] + ch + 1) % 256;
    end else begin
      m_result = 0;
    end
    m_count = (m_count + 1) % 65536;
    if (m_unread) m_over = 1;
    m_unread = 1;
    m_done = 1;
  endfunction

  // Monitor: each new read beat is scored against the oldest expectation.
  logic prev_oe = 1'b0;
  always @(negedge clk) begin
    if (adc_oe && !prev_oe) begin
      if (exp_q.size() == 0) check("unexpected_read", 1, 0);
      else check("read_data", int'(adc_out), exp_q.pop_front());
    end
    prev_oe <= adc_oe;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; n_convst = 1'b1; n_cs = 1'b1; n_rd = 1'b1;
    tick();
    reset = 1'b0;
    m_reset();
  endtask

  task automatic pulse_start(input int ch);
    chnl = 3'(ch); n_convst = 1'b0;
    tick();
    n_convst = 1'b1;
    m_done = 0;
  endtask

  task automatic wait_eoc(input int ch);
    int k;
    for (k = 1; k <= CONV + 20; k++) begin
      tick();
      if (!n_eoc) break;
    end
    check("eoc_latency", k, CONV);
    m_complete(ch);
    check("conv_count", int'(conv_count), m_count);
    check("overrun", int'(overrun), int'(m_over));
  endtask

  task automatic convert(input int ch);
    pulse_start(ch);
    wait_eoc(ch);
  endtask

  task automatic read_data();
    bit was_done = m_done;
    n_cs = 1'b0; n_rd = 1'b0;
    exp_q.push_back(m_result);
    tick();
    n_rd = 1'b1;
    tick();
    n_cs = 1'b1;
    if (was_done) begin
      m_unread = 0; m_done = 0;
      check("eoc_release", int'(n_eoc), 1);
    end
  endtask

  // Read completes on the same edge a new start is detected.
  task automatic read_with_start(input int ch);
    n_cs = 1'b0; n_rd = 1'b0;
    exp_q.push_back(m_result);
    tick();
    n_rd = 1'b1; chnl = 3'(ch); n_convst = 1'b0;
    tick();
    n_cs = 1'b1; n_convst = 1'b1;
    m_unread = 0; m_done = 0;
    check("start_wins", int'(n_eoc), 1);
    wait_eoc(ch);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    m_reset();
    repeat (2) tick();
    do_reset();
    check("rst_n_eoc", int'(n_eoc), 1);
    check("rst_adc_oe", int'(adc_oe), 0);
    check("rst_adc_out", int'(adc_out), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_count", int'(conv_count), 0);

    // Single conversion and read on channel 0.
    convert(0);
    read_data();

    // Round robin, two passes.
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 4; c++) begin
        convert(c);
        read_data();
      end

    // Abort mid-conversion.
    pulse_start(2);
    repeat (2) tick();
    convert(2);
    read_data();
    convert(2);
    read_data();

    // Two conversions without a read set overrun; it is sticky.
    convert(1);
    convert(1);
    tick();
    check("overrun_sticky", int'(overrun), 1);
    read_data();
    check("overrun_after_read", int'(overrun), 1);
    do_reset();
    check("overrun_cleared", int'(overrun), 0);

    // Dead channel returns zero and leaves ramps alone.
    convert(5);
    read_data();
    convert(3);
    read_data();

    // Reset during a conversion: no late end-of-conversion.
    pulse_start(1);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rstconv_n_eoc", int'(n_eoc), 1);
    check("rstconv_adc_oe", int'(adc_oe), 0);
    check("rstconv_adc_out", int'(adc_out), 0);
    reset = 1'b0;
    m_reset();
    lows = 0;
    repeat (CONV + 4) begin
      tick();
      if (!n_eoc) lows++;
    end
    check("no_late_eoc", lows, 0);
    convert(1);
    read_data();

    // Reset during the read phase.
    convert(2);
    n_cs = 1'b0; n_rd = 1'b0; reset = 1'b1;
    tick();
    check("rstrd_adc_oe", int'(adc_oe), 0);
    check("rstrd_adc_out", int'(adc_out), 0);
    check("rstrd_n_eoc", int'(n_eoc), 1);
    reset = 1'b0; n_cs = 1'b1; n_rd = 1'b1;
    m_reset();
    tick();
    check("rstrd_oe_idle", int'(adc_oe), 0);
    convert(2);
    read_data();

    // Randomized operation mix.
    for (int i = 0; i < 200; i++) begin
      int ch;
      int op;
      ch = int'($urandom_range(0, 7));
      op = int'($urandom_range(0, 3));
      case (op)
        0: begin convert(ch); read_data(); end
        1: convert(ch);
        2: begin
          pulse_start(int'($urandom_range(0, 7)));
          repeat (int'($urandom_range(1, CONV - 2))) tick();
          convert(ch);
        end
        default: begin
          if (m_done) read_with_start(ch);
          else begin convert(ch); read_data(); end
        end
      endcase
    end

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adc_emulator.md
Name: adc_emulator

Overview:
- Synthesizable stand-in for the 8-bit, 8-input parallel ADC that the sampler front end drives.
- Implements the responder side of the ADC interface: start conversion, end-of-conversion indication, chip-select/read data phase.
- Returns deterministic per-channel ramp data, so sampler and downstream beamforming logic can be tested in loopback on the FPGA or in simulation without the physical ADC.

Parameters:
CONV_CYCLES, 8, clk cycles from detected start of conversion to n_eoc assertion; legal range 1..255
NUM_CH, 4, channels with live ramp data (channels NUM_CH..7 return 8'h00); legal range 1..8

Ports:
clk  input  1  system clock; all logic on posedge clk
reset  input  1  synchronous, active-high reset
chnl  input  3  channel address, latched on detected n_convst falling edge
n_convst  input  1  active-low start-conversion request
n_cs  input  1  active-low chip select
n_rd  input  1  active-low read strobe
n_eoc  output  1  active-low end of conversion
adc_out  output  8  conversion result bus
adc_oe  output  1  bus drive enable; a top-level tristate uses it when driving pins
overrun  output  1  sticky flag: a conversion finished while the previous result was unread
conv_count  output  16  number of completed conversions, wraps at 16'hFFFF -> 0

Behaviour:
- One clock, one domain. All inputs are treated as synchronous to clk; there are no internal synchronizers. Asynchronous pin use needs a synchronizer at top level.
- Reset values (registered on the reset cycle):
  - n_eoc=1, adc_out=8'h00, adc_oe=0, overrun=0, conv_count=0
  - state=IDLE, n_convst_q=1, n_rd_q=1, result=8'h00
  - ramp[k]=k*8'h40 (8'h00, 8'h40, 8'h80, 8'hC0); for NUM_CH>4 the value wraps mod 256
- Reset overrides everything, including mid-conversion and mid-read.
- Start detect: start = n_convst_q & ~n_convst, where n_convst_q is the previous-cycle value. On start, latch ch_lat=chnl and load cnt=CONV_CYCLES-1.
- State machine states: IDLE, CONVERTING, DONE.
  - IDLE -> CONVERTING on start.
  - CONVERTING: cnt decrements each cycle. When cnt==0:
    - result=ramp[ch_lat]
    - ramp[ch_lat] += ch_lat+1, mod 256
    - conv_count+=1
    - n_eoc<=0; go to DONE
    - If ch_lat>=NUM_CH: result=8'h00 and no ramp update.
  - Timing: start detected in cycle t -> n_eoc low from cycle t+CONV_CYCLES.
  - DONE: n_eoc held low until the read completes or a new start arrives.
- Start while CONVERTING: abort, relatch chnl, reload cnt. No ramp update and no count for the aborted conversion.
- Start while DONE: n_eoc<=1 and go to CONVERTING; the unread result is discarded. When the new conversion completes, overrun<=1 because the result was unread.
- Read phase, in any state:
  - adc_oe registered = ~n_cs & ~n_rd, so 1-cycle latency.
  - adc_out registered = result whenever ~n_cs & ~n_rd, otherwise holds its last value.
- Read complete: rising edge of n_rd (n_rd_q=0, n_rd=1) with n_cs=0 in the same cycle.
  - In DONE: n_eoc<=1, go to IDLE, mark the result read.
  - In IDLE/CONVERTING: no state effect.
- Unread flag:
  - Set at each conversion completion.
  - Cleared on read complete in DONE.
  - If a completion occurs while unread=1, overrun<=1 (sticky until reset).
- Simultaneous start and read-complete in DONE: start wins (go to CONVERTING); the read still clears unread.
- Ramp wrap: 8'hFF + step wraps modulo 256 (e.g. ch3 8'hFE+4 -> 8'h02).

Test Plan:
- Reset, then a single conversion on chnl=0 with CONV_CYCLES=8 -> n_eoc low exactly 8 cycles after the start-detect cycle; cs/rd low -> adc_oe=1 and adc_out=8'h00 one cycle later; rd rising -> n_eoc=1, conv_count=1.
- Round-robin over chnl 0..3, twice, each read -> first pass 00,40,80,C0; second pass 01,42,83,C4; overrun=0; conv_count=8.
- Re-issue n_convst mid-conversion at cycle 3 on chnl=2 -> n_eoc low 8 cycles after the second start; read data 8'h80; ramp[2] advanced once only (next ch2 read 8'h83).
- Two conversions on chnl=1 without a read -> overrun=1 after the second completes and stays 1; the read returns 8'h42; reset clears overrun.
- chnl=5 with NUM_CH=4 -> read returns 8'h00, conv_count increments, ramps unchanged.
- Assert reset during CONVERTING and during the read phase -> next cycle n_eoc=1, adc_oe=0, adc_out=8'h00, all ramps back to reset values, no late n_eoc.
